// File: rtl/e203_exu_fpu_fmis_arb_if.sv
// Handshake bundles for the FPU misc-path converter arbiter: one requester/response
// port bundle (instantiated per requester) and the converter-side bundle.
interface e203_exu_fpu_fmis_arb_port_if #(parameter int TAG_W = 3);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_rs1;
  logic             req_uns;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_wdat;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req_valid, req_rs1, req_uns, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_wdat, rsp_tag, rsp_err
  );
  modport slave (
    input  req_valid, req_rs1, req_uns, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_wdat, rsp_tag, rsp_err
  );
endinterface

interface e203_exu_fpu_fmis_arb_cvt_if;
  logic        u_i_valid;
  logic        u_i_ready;
  logic [31:0] u_rs1;
  logic        u_flag;
  logic        u_o_valid;
  logic        u_o_ready;
  logic [31:0] u_wdat;
  logic        u_flush;

  modport master (
    output u_i_valid, u_rs1, u_flag, u_o_ready, u_flush,
    input  u_i_ready, u_o_valid, u_wdat
  );
  modport slave (
    input  u_i_valid, u_rs1, u_flag, u_o_ready, u_flush,
    output u_i_ready, u_o_valid, u_wdat
  );
endinterface

// File: rtl/e203_exu_fpu_fmis_arb.sv
// Two-port round-robin arbiter/sequencer for the shared int-to-float converter.
// Optional WAIT watchdog enabled by defining E203_FMIS_ARB_TMO_EN.
module e203_exu_fpu_fmis_arb #(
  parameter int TAG_W   = 3,
  parameter int TMO_CYC = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  e203_exu_fpu_fmis_arb_port_if.slave        port0,
  e203_exu_fpu_fmis_arb_port_if.slave        port1,
  e203_exu_fpu_fmis_arb_cvt_if.master        cvt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [31:0]      op_rs1_q, op_rs1_d;
  logic             op_uns_q, op_uns_d;
  logic [TAG_W-1:0] op_tag_q, op_tag_d;
  logic             owner_q, owner_d;
  logic [31:0]      res_q, res_d;
  logic             err_q, err_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             flush_q, flush_d;
  logic             u_i_valid_q, u_i_valid_d;
  logic             u_o_ready_q, u_o_ready_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic             gnt_any;
  logic             gnt_id;
  logic             tmo_hit;

  assign req_valid = {port1.req_valid, port0.req_valid};
  assign rsp_ready = {port1.rsp_ready, port0.rsp_ready};

  // Contention resolves to rr_ptr; a lone requester always wins.
  assign gnt_any = |req_valid;
  assign gnt_id  = (&req_valid) ? rr_ptr_q : req_valid[1];

  assign port0.req_ready = (state_q == IDLE) & gnt_any & ~gnt_id;
  assign port1.req_ready = (state_q == IDLE) & gnt_any &  gnt_id;

`ifdef E203_FMIS_ARB_TMO_EN
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Count holds zero outside WAIT, so it is already clear on WAIT entry.
  assign tmo_cnt_d = (state_q == WAIT) ? tmo_cnt_q + 1'b1 : '0;
  assign tmo_hit   = (state_q == WAIT) && (tmo_cnt_q == CNT_W'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_rs1_d = op_rs1_q;
    op_uns_d = op_uns_q;
    op_tag_d = op_tag_q;
    owner_d  = owner_q;
    res_d    = res_q;
    err_d    = err_q;
    rr_ptr_d = rr_ptr_q;
    flush_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          op_rs1_d = gnt_id ? port1.req_rs1 : port0.req_rs1;
          op_uns_d = gnt_id ? port1.req_uns : port0.req_uns;
          op_tag_d = gnt_id ? port1.req_tag : port0.req_tag;
          owner_d  = gnt_id;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (cvt.u_i_ready) state_d = WAIT;
      end
      WAIT: begin
        // A result landing on the timeout cycle still counts as a normal completion.
        if (cvt.u_o_valid) begin
          res_d   = cvt.u_wdat;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_hit) begin
          res_d   = 32'h7FC0_0000;
          err_d   = 1'b1;
          flush_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rr_ptr_d = ~owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    u_i_valid_d    = (state_d == ISSUE);
    u_o_ready_d    = (state_d == WAIT);
    rsp_valid_d[0] = (state_d == RESP) && !owner_d;
    rsp_valid_d[1] = (state_d == RESP) &&  owner_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_rs1_q    <= '0;
      op_uns_q    <= 1'b0;
      op_tag_q    <= '0;
      owner_q     <= 1'b0;
      res_q       <= '0;
      err_q       <= 1'b0;
      rr_ptr_q    <= 1'b0;
      flush_q     <= 1'b0;
      u_i_valid_q <= 1'b0;
      u_o_ready_q <= 1'b0;
      rsp_valid_q <= '0;
`ifdef E203_FMIS_ARB_TMO_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_rs1_q    <= op_rs1_d;
      op_uns_q    <= op_uns_d;
      op_tag_q    <= op_tag_d;
      owner_q     <= owner_d;
      res_q       <= res_d;
      err_q       <= err_d;
      rr_ptr_q    <= rr_ptr_d;
      flush_q     <= flush_d;
      u_i_valid_q <= u_i_valid_d;
      u_o_ready_q <= u_o_ready_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef E203_FMIS_ARB_TMO_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign cvt.u_i_valid = u_i_valid_q;
  assign cvt.u_rs1     = op_rs1_q;
  assign cvt.u_flag    = op_uns_q;
  assign cvt.u_o_ready = u_o_ready_q;
  assign cvt.u_flush   = flush_q;

  assign port0.rsp_valid = rsp_valid_q[0];
  assign port0.rsp_wdat  = res_q;
  assign port0.rsp_tag   = op_tag_q;
  assign port0.rsp_err   = err_q;
  assign port1.rsp_valid = rsp_valid_q[1];
  assign port1.rsp_wdat  = res_q;
  assign port1.rsp_tag   = op_tag_q;
  assign port1.rsp_err   = err_q;

endmodule

// File: tb/tb_e203_exu_fpu_fmis_arb.sv
// Self-checking bench for e203_exu_fpu_fmis_arb: requester/converter models plus
// a scoreboard of expected responses filled at request handshake.
module tb_e203_exu_fpu_fmis_arb;

  localparam int TAG_W = 3;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  e203_exu_fpu_fmis_arb_port_if #(.TAG_W(TAG_W)) p0 ();
  e203_exu_fpu_fmis_arb_port_if #(.TAG_W(TAG_W)) p1 ();
  e203_exu_fpu_fmis_arb_cvt_if                   cv ();

  e203_exu_fpu_fmis_arb #(.TAG_W(TAG_W), .TMO_CYC(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .port0 (p0),
    .port1 (p1),
    .cvt   (cv)
  );

  typedef struct { logic [31:0] rs1; logic uns; logic [TAG_W-1:0] tag; logic [31:0] wdat; logic err; } req_t;
  typedef struct { int port; logic [TAG_W-1:0] tag; logic [31:0] wdat; logic err; } exp_t;
  typedef struct { logic [31:0] rs1; logic uns; } iss_t;

  req_t rq0[$], rq1[$];
  exp_t expq[$];
  iss_t issq[$];
  int   gnt_log[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   outstanding = 0;
  int   wait_cyc = 0, flush_cnt = 0, bp_cyc = 0, bp_done = 0, hold_cnt = 0;
  bit   bp_have = 0;
  logic [36:0] bp_snap;

  // knobs written only by the main sequence
  int   bp_req = 0, lat_max = 0;
  bit   hang = 0, irdy_rand = 0, stray_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference int32/uint32 -> IEEE single, round-to-nearest-even.
  function automatic logic [31:0] i2f(input logic [31:0] x, input logic uns);
    logic s; logic [31:0] mag, rem, half; logic [24:0] m; logic [7:0] e; int p, sh;
    s   = !uns && x[31];
    mag = s ? (~x + 32'd1) : x;
    if (mag == 32'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    e = 8'(127 + p);
    if (p <= 23) begin
      m = 25'(mag << (23 - p));
    end else begin
      sh   = p - 23;
      m    = 25'(mag >> sh);
      rem  = mag & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 25'd1;
      if (m[24]) begin m = m >> 1; e = e + 8'd1; end
    end
    return {s, e, m[22:0]};
  endfunction

  // Requester, converter and response-side environment; sampled at negedge, driven at posedge+1.
  initial begin
    bit h_req0, h_req1, h_i, h_o, h_rsp0, h_rsp1, rst_s, fl_s, cv_busy, cv_done;
    int cv_cnt, pp;
    logic [31:0] cv_res;
    req_t r; exp_t x; iss_t s;
    cv_busy = 0; cv_done = 0; cv_cnt = 0; cv_res = '0;
    p0.req_valid = 0; p0.req_rs1 = '0; p0.req_uns = 0; p0.req_tag = '0; p0.rsp_ready = 1;
    p1.req_valid = 0; p1.req_rs1 = '0; p1.req_uns = 0; p1.req_tag = '0; p1.rsp_ready = 1;
    cv.u_i_ready = 1; cv.u_o_valid = 0; cv.u_wdat = '0;
    forever begin
      @(negedge clk);
      rst_s  = rst;
      h_req0 = p0.req_valid & p0.req_ready;
      h_req1 = p1.req_valid & p1.req_ready;
      h_i    = cv.u_i_valid & cv.u_i_ready;
      h_o    = cv.u_o_valid & cv.u_o_ready;
      fl_s   = cv.u_flush;
      h_rsp0 = p0.rsp_valid & p0.rsp_ready;
      h_rsp1 = p1.rsp_valid & p1.rsp_ready;
      if (rst_s) begin
        expq.delete(); issq.delete(); outstanding = 0; bp_have = 0;
      end else begin
        chk("ready_busy", (p0.req_ready | p1.req_ready) & outstanding, 0);
        chk("rsp_both", p0.rsp_valid & p1.rsp_valid, 0);
        if (cv.u_o_ready) wait_cyc++;
        if (fl_s) begin flush_cnt++; chk("tmo_wait_cycles", wait_cyc, TMO); end
        if (h_req0 || h_req1) begin
          r  = h_req0 ? rq0[0] : rq1[0];
          pp = h_req0 ? 0 : 1;
          gnt_log.push_back(pp);
          expq.push_back('{pp, r.tag, r.wdat, r.err});
          issq.push_back('{r.rs1, r.uns});
          outstanding = 1; wait_cyc = 0;
          $display("[TB] req port=%0d rs1=%h uns=%0d tag=%0d", pp, r.rs1, r.uns, r.tag);
        end
        if (h_i) begin
          chk("iss_expected", issq.size() > 0, 1);
          if (issq.size() > 0) begin
            s = issq.pop_front();
            chk("u_rs1", cv.u_rs1, s.rs1);
            chk("u_flag", cv.u_flag, s.uns);
          end
        end
        if (p1.rsp_valid && !p1.rsp_ready) begin
          if (bp_have) chk("bp_stable", {p1.rsp_valid, p1.rsp_err, 32'(p1.rsp_tag) ^ p1.rsp_wdat, p1.rsp_tag}, bp_snap);
          bp_snap = {p1.rsp_valid, p1.rsp_err, 32'(p1.rsp_tag) ^ p1.rsp_wdat, p1.rsp_tag};
          bp_have = 1; bp_cyc++;
          chk("bp_req0_ready", p0.req_ready, 0);
        end
        if (h_rsp0 || h_rsp1) begin
          pp = h_rsp1 ? 1 : 0;
          chk("rsp_expected", expq.size() > 0, 1);
          if (expq.size() > 0) begin
            x = expq.pop_front();
            chk("rsp_port", pp, x.port);
            chk("rsp_wdat", pp ? p1.rsp_wdat : p0.rsp_wdat, x.wdat);
            chk("rsp_tag", pp ? p1.rsp_tag : p0.rsp_tag, x.tag);
            chk("rsp_err", pp ? p1.rsp_err : p0.rsp_err, x.err);
          end
          if (h_rsp1 && bp_have) begin chk("bp_cycles", bp_cyc, 10); bp_done++; end
          bp_have = 0; bp_cyc = 0; outstanding = 0;
          $display("[TB] rsp port=%0d wdat=%h tag=%0d err=%0d", pp,
                   pp ? p1.rsp_wdat : p0.rsp_wdat, pp ? p1.rsp_tag : p0.rsp_tag, pp ? p1.rsp_err : p0.rsp_err);
        end
      end

      @(posedge clk); #1;
      if (h_req0) rq0.delete(0);
      if (h_req1) rq1.delete(0);
      p0.req_valid = rq0.size() > 0;
      if (rq0.size() > 0) begin p0.req_rs1 = rq0[0].rs1; p0.req_uns = rq0[0].uns; p0.req_tag = rq0[0].tag; end
      p1.req_valid = rq1.size() > 0;
      if (rq1.size() > 0) begin p1.req_rs1 = rq1[0].rs1; p1.req_uns = rq1[0].uns; p1.req_tag = rq1[0].tag; end

      if (rst_s) begin
        cv_busy = 0; cv_done = 0;
      end else begin
        if (h_o || fl_s) begin cv_busy = 0; cv_done = 0; end
        if (h_i) begin
          cv_busy = 1; cv_done = 0;
          cv_cnt  = $urandom_range(0, lat_max);
          cv_res  = i2f(cv.u_rs1, cv.u_flag);
        end
        if (cv_busy && !cv_done && !hang) begin
          if (cv_cnt == 0) cv_done = 1; else cv_cnt--;
        end
      end
      cv.u_o_valid = cv_busy ? cv_done : stray_on;
      cv.u_wdat    = cv_busy ? cv_res : 32'hDEAD_BEEF;
      cv.u_i_ready = irdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

      if (p1.rsp_valid) begin
        p1.rsp_ready = (hold_cnt >= bp_req);
        if (!p1.rsp_ready) hold_cnt++;
      end else begin
        hold_cnt = 0; p1.rsp_ready = 1;
      end
    end
  end

  task automatic push(input int port, input logic [31:0] rs1, input logic uns,
                      input logic [TAG_W-1:0] tag, input logic [31:0] wdat, input logic err);
    if (port == 0) rq0.push_back('{rs1, uns, tag, wdat, err});
    else           rq1.push_back('{rs1, uns, tag, wdat, err});
  endtask

  task automatic push_rand(input int port);
    logic [31:0] v; logic u;
    v = $urandom; u = 1'($urandom_range(0, 1));
    push(port, v, u, TAG_W'($urandom_range(0, 7)), i2f(v, u), 1'b0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || outstanding) && n < budget) begin
      @(negedge clk); n++;
    end
    chk("drain_done", (rq0.size() == 0 && rq1.size() == 0 && !outstanding), 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_rst(input string name);
    chk({name, "_ctl"}, {p0.req_ready, p1.req_ready, p0.rsp_valid, p1.rsp_valid, p0.rsp_err, p1.rsp_err,
                         cv.u_i_valid, cv.u_o_ready, cv.u_flush, cv.u_flag}, 0);
    chk({name, "_wdat"}, {p0.rsp_wdat, p1.rsp_wdat}, 0);
    chk({name, "_tag_rs1"}, {p0.rsp_tag, p1.rsp_tag, cv.u_rs1}, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    int base, d0, f0;
    bit seen;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("reset");
    @(posedge clk); #1 rst = 0;

    // single request
    push(0, 32'd1, 1'b0, 3'd5, 32'h3F80_0000, 1'b0);
    drain(60);

    // simultaneous requests right after reset: port 0 first
    do_reset();
    base = gnt_log.size();
    push(0, 32'hFFFF_FFFE, 1'b0, 3'd1, 32'hC000_0000, 1'b0);
    push(1, 32'hFFFF_FFFF, 1'b1, 3'd2, 32'h4F80_0000, 1'b0);
    drain(80);
    chk("simul_count", gnt_log.size() - base, 2);
    for (int i = 0; i < 2 && base + i < gnt_log.size(); i++) chk("simul_order", gnt_log[base + i], i);

    // fairness with both continuously valid
    lat_max = 2;
    base = gnt_log.size();
    for (int i = 0; i < 3; i++) begin push_rand(0); push_rand(1); end
    drain(300);
    chk("fair_count", gnt_log.size() - base, 6);
    for (int i = 0; i < 6 && base + i < gnt_log.size(); i++) chk("fair_order", gnt_log[base + i], i % 2);

    // response backpressure on port 1 with port 0 waiting
    lat_max = 0; bp_req = 10; d0 = bp_done;
    push(1, 32'd100, 1'b0, 3'd6, 32'h42C8_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1 push(0, 32'd3, 1'b1, 3'd7, 32'h4040_0000, 1'b0);
    drain(100);
    bp_req = 0;
    chk("bp_seen", bp_done - d0, 1);

    // reset during WAIT, then a stray converter result
    hang = 1;
    push(0, 32'd7, 1'b0, 3'd3, 32'h40E0_0000, 1'b0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = cv.u_o_ready; end
    chk("reach_wait", seen, 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; hang = 0; stray_on = 1;
    @(negedge clk);
    chk_rst("midrst");
    repeat (3) begin @(negedge clk); chk("stray_oready", cv.u_o_ready, 0); end
    @(posedge clk); #1 stray_on = 0;
    repeat (3) @(posedge clk);
    #1 push(1, 32'h8000_0000, 1'b0, 3'd4, 32'hCF00_0000, 1'b0);
    drain(60);

    // randomized mix with converter accept stalls
    irdy_rand = 1; lat_max = 3;
    for (int i = 0; i < 10; i++) push_rand(int'($urandom_range(0, 1)));
    drain(500);
    irdy_rand = 0; lat_max = 0;

`ifdef E203_FMIS_ARB_TMO_EN
    // watchdog: converter never answers
    hang = 1; f0 = flush_cnt;
    push(0, 32'd9, 1'b0, 3'd2, 32'h7FC0_0000, 1'b1);
    drain(100);
    chk("flush_pulses", flush_cnt - f0, 1);
    hang = 0;
`else
    f0 = flush_cnt;
    chk("no_flush", flush_cnt - f0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
